// File: rtl/uart_rx.sv
// 8N1 UART receiver with read-strobe handshake and sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       ferr,
  output logic       ovf,
  output logic       perr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
    $error("uart_rx: illegal parameter values");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic             rx_s1;
  logic             rx_s2;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic perr_q;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;

      // Later assignments below (frame completion, error sets) override a read clear.
      if (rd) begin
        rx_rdy <= 1'b0;
        ferr   <= 1'b0;
        ovf    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s2) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            sr      <= {rx_s2, sr[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= (^sr ^ rx_s2) != PARITY_ODD[0];
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              state <= IDLE;
              // A read in the completion cycle frees the buffer for the new byte.
              if (!rx_rdy || rd) begin
                rx_data <= sr;
                rx_rdy  <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                perr_q <= 1'b1;
              end
`endif
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s2) begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// Observed/expected values are shown as {rx_data, rx_rdy, ferr, ovf, perr} in hex.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Negedge index (from frame start) whose rd pulse lands on the stop-sample edge.
  localparam int RD_AT_DONE = 11 + CPB * (NB - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       ferr;
  logic       ovf;
  logic       perr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rd      (rd),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .ferr    (ferr),
    .ovf     (ovf),
    .perr    (perr)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {1'b0, stop, d, 1'b0};
`endif
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {rx_data, rx_rdy, ferr, ovf, perr};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int rd_at);
    for (int t = 0; t < CPB * NB; t++) begin
      @(negedge clk);
      rx = bits[t / CPB];
      rd = (t == rd_at);
    end
    @(negedge clk);
    rx = 1'b1;
    rd = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    rx  = 1'b1;
    rd  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {8'h00, 4'b0000});
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_bits(frame(8'hA5, 1'b1), -1);
    check("a5_rx", {8'hA5, 4'b1000});
    pulse_rd();
    check("a5_rd", {8'hA5, 4'b0000});

    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch", {8'hA5, 4'b0000});

    send_bits(frame(8'h3C, 1'b0), -1);
    check("ferr_set", {8'hA5, 4'b0100});
    pulse_rd();
    check("ferr_clr_rd_idle", {8'hA5, 4'b0000});

    send_bits(frame(8'h11, 1'b1), -1);
    check("after_ferr_11", {8'h11, 4'b1000});
    pulse_rd();

    send_bits(frame(8'h01, 1'b1), -1);
    send_bits(frame(8'h02, 1'b1), -1);
    check("ovf_set", {8'h01, 4'b1010});
    pulse_rd();
    check("ovf_clr", {8'h01, 4'b0000});

    send_bits(frame(8'h01, 1'b1), -1);
    check("coinc_first", {8'h01, 4'b1000});
    send_bits(frame(8'h02, 1'b1), RD_AT_DONE);
    check("coinc_rd", {8'h02, 4'b1000});

`ifdef UART_RX_PARITY_EN
    pulse_rd();
    send_bits({1'b1, 1'b0, 8'h01, 1'b0}, -1);
    check("par_bad", {8'h01, 4'b1001});
    pulse_rd();
    send_bits({1'b1, 1'b1, 8'h01, 1'b0}, -1);
    check("par_good", {8'h01, 4'b1000});
`endif

    // 0xFF frame cut during data bit 4 (start + 4 bits + half a bit).
    for (int t = 0; t < CPB * 5 + CPB / 2; t++) begin
      @(negedge clk);
      rx = (t >= CPB);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid", {8'h00, 4'b0000});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_idle", {8'h00, 4'b0000});

    send_bits(frame(8'h5A, 1'b1), -1);
    check("after_rst_5a", {8'h5A, 4'b1000});
    pulse_rd();
    check("after_rst_rd", {8'h5A, 4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit; legal minimum 4.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-003 Port clk SHALL be input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be input, width 1: asynchronous, active-high reset.
REQ-005 Port rx SHALL be input, width 1: asynchronous serial line, idle high.
REQ-006 Port rd SHALL be input, width 1: consumer read strobe, one clk pulse.
REQ-007 Port rx_data SHALL be output, width 8: last accepted byte.
REQ-008 Port rx_rdy SHALL be output, width 1: rx_data holds an unread byte.
REQ-009 Port ferr SHALL be output, width 1: sticky framing-error flag.
REQ-010 Port ovf SHALL be output, width 1: sticky overrun flag.
REQ-011 Port perr SHALL be output, width 1: sticky parity-error flag.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 Frame format SHALL be: 1 start (0), 8 data bits LSB first, optional parity bit, 1 stop (1).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; reset state SHALL be IDLE.
REQ-015 IDLE -> START SHALL occur on a synchronized 0; the bit counter SHALL clear.
REQ-016 START SHALL sample at count CLKS_PER_BIT/2 (integer divide); a sample of 1 SHALL return to IDLE as a glitch, with no flag set.
REQ-017 A START sample of 0 SHALL go to DATA.
REQ-018 DATA SHALL sample every CLKS_PER_BIT clks; the sample SHALL shift into bit index 0..7 in order.
REQ-019 After the 8th sample, DATA SHALL go to PARITY when the parity macro is defined, else to STOP.
REQ-020 PARITY SHALL sample one bit CLKS_PER_BIT later and record a mismatch against the configured parity, then go to STOP.
REQ-021 STOP SHALL sample one bit after the preceding sample.
REQ-022 A STOP sample of 1 SHALL complete the frame and go to IDLE.
REQ-023 A STOP sample of 0 SHALL set ferr, discard the byte and go to WAIT_IDLE.
REQ-024 WAIT_IDLE SHALL go to IDLE once the synchronized rx is 1.
REQ-025 On frame completion with rx_rdy=0, rx_data SHALL load the shift register and rx_rdy SHALL assert on the clk after the stop sample.
REQ-026 On frame completion, a recorded parity mismatch SHALL also set perr on that same clk.
REQ-027 On frame completion with rx_rdy=1 and rd=0, the new byte SHALL be dropped, rx_data SHALL stay unchanged, and ovf SHALL set.
REQ-028 If rd=1 in the same clk as completion, completion SHALL win: new byte loaded, rx_rdy stays 1, ovf not set.
REQ-029 Otherwise, rd=1 SHALL clear rx_rdy, ferr, ovf and perr on the next edge; rd with rx_rdy=0 SHALL still clear the flags.
REQ-030 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, wrap to 0 at CLKS_PER_BIT-1, and never free-run in IDLE.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, counter 0, synchronizer flops 1, rx_data 8'h00, rx_rdy 0, ferr 0, ovf 0, perr 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no flag set; after release, reception SHALL restart only on a new falling edge.

Configuration
REQ-033 With macro UART_RX_PARITY_EN defined, the PARITY state and the perr logic SHALL be compiled in per REQ-020 and REQ-026.
REQ-034 With UART_RX_PARITY_EN undefined, PARITY SHALL be unreachable and perr SHALL be constant 0; the port list SHALL be unchanged.

Verification (CLKS_PER_BIT=16)
REQ-035 Serial 0xA5, good stop -> rx_data=8'hA5, rx_rdy=1, ferr=ovf=perr=0; rd pulse -> rx_rdy=0 next clk.
REQ-036 rx low for 4 clks, then high -> remains IDLE, rx_rdy=0, no flags.
REQ-037 0x3C with stop bit 0 -> ferr=1, rx_rdy=0, rx_data unchanged; next valid 0x11 after line high -> rx_data=8'h11.
REQ-038 0x01 then 0x02, no rd -> rx_data=8'h01, rx_rdy=1, ovf=1; repeat with rd coincident with the 0x02 completion -> rx_data=8'h02, ovf=0.
REQ-039 Parity macro on, PARITY_ODD=0, 0x01 with parity bit 0 -> rx_data=8'h01, perr=1; parity bit 1 -> perr=0.
REQ-040 rst pulsed during data bit 4 of 0xFF -> all outputs reset; next frame 0x5A received correctly.
